sram_port_arbiter: RTL and testbench

- Shares one SRAM-like bus port between the instruction-fetch master and the data master (EX issues requests, MEM consumes data_ok/rdata).
- Tracks in-flight transactions in order, routes each response to its owner, and discards responses for fetches cancelled by exception/ERET flush.
- Sits between the CPU core and the cache/AXI bridge.

---
 rtl/sram_port_arbiter_if.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared SRAM-like bus port.
// The master modport is the arbiter's view; the slave modport is the core and bridge side.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    input  inst_req, inst_addr, inst_cancel,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  addr_ok, data_ok, rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output req, wr, size, wstrb, addr, wdata
  );

  modport slave (
    output inst_req, inst_addr, inst_cancel,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output addr_ok, data_ok, rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  req, wr, size, wstrb, addr, wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bus between fetch and data masters, routing responses in order.
// Optional macro ARB_ROUND_ROBIN_EN: alternate priority on contention instead of data-first.
module sram_port_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input logic                 clk,
  input logic                 reset,
  sram_port_arbiter_if.master bus
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD_I = 2'd1;
  localparam logic [1:0] HOLD_D = 2'd2;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          count;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OUTSTANDING-1:0] ent_src, ent_discard;
  logic                   cancel_sticky;
  logic                   grant_i, grant_d, pick_d;
  logic                   push, pop, head_src, head_discard;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data;
  assign pick_d = bus.data_req & (~bus.inst_req | ~last_data);
`else
  assign pick_d = bus.data_req;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      HOLD_I:  grant_i = 1'b1;
      HOLD_D:  grant_d = 1'b1;
      default: if (count < FULL) begin
        grant_d = pick_d;
        grant_i = bus.inst_req & ~pick_d;
      end
    endcase
  end

  assign push         = (grant_i | grant_d) & bus.addr_ok;
  assign pop          = bus.data_ok & (count != '0);
  assign head_src     = ent_src[rd_ptr];
  assign head_discard = ent_discard[rd_ptr];

  // A request accepted from IDLE never enters HOLD; after acceptance we return to
  // IDLE, which arbitrates combinationally so back-to-back issue is possible.
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if ((grant_i | grant_d) & ~bus.addr_ok)
        state_nxt = grant_d ? HOLD_D : HOLD_I;
    end else if (bus.addr_ok) begin
      state_nxt = IDLE;
    end
  end

  // All outputs are forced low while reset is asserted.
  always_comb begin
    bus.req          = 1'b0;
    bus.wr           = 1'b0;
    bus.size         = 2'd0;
    bus.wstrb        = 4'd0;
    bus.addr         = 32'd0;
    bus.wdata        = 32'd0;
    bus.inst_addr_ok = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.inst_rdata   = 32'd0;
    bus.data_rdata   = 32'd0;
    if (reset) begin
      bus.req          = grant_i | grant_d;
      bus.inst_addr_ok = bus.addr_ok & grant_i;
      bus.data_addr_ok = bus.addr_ok & grant_d;
      bus.inst_data_ok = pop & (head_src == SRC_INST) & ~head_discard & ~bus.inst_cancel;
      bus.data_data_ok = pop & (head_src == SRC_DATA);
      bus.inst_rdata   = bus.rdata;
      bus.data_rdata   = bus.rdata;
      if (grant_d) begin
        bus.wr    = bus.data_wr;
        bus.size  = bus.data_size;
        bus.wstrb = bus.data_wstrb;
        bus.addr  = bus.data_addr;
        bus.wdata = bus.data_wdata;
      end else if (grant_i) begin
        bus.size  = 2'd2;
        bus.addr  = bus.inst_addr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      // NOTE: the tracking entries are a handful of flags, so they are reset
      // explicitly; stale discard bits must never survive a reset.
      ent_src       <= '0;
      ent_discard   <= '0;
      cancel_sticky <= 1'b0;
    end else begin
      state <= state_nxt;

      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // Marking every fetch slot is harmless: free slots are rewritten on push.
      if (bus.inst_cancel) ent_discard <= ent_discard | ~ent_src;
      if (push) begin
        ent_src[wr_ptr]     <= grant_d;
        ent_discard[wr_ptr] <= grant_i & (bus.inst_cancel | cancel_sticky);
      end

      if (push & grant_i)
        cancel_sticky <= 1'b0;
      else if ((state == HOLD_I) & bus.inst_cancel)
        cancel_sticky <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_data <= 1'b0;
    else if ((state == IDLE) & (grant_i | grant_d))
      last_data <= grant_d;
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table, corner sequences and
// randomized traffic compared against a queue-based transaction model.
module tb_sram_port_arbiter;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(.OUTSTANDING(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic src; logic disc; } ent_t;  // src: 0 inst, 1 data
  ent_t q[$];
  int   holder;            // 0 none, 1 fetch held, 2 data held
  bit   sticky, last_d;
  int   g_m;
  bit   pop_m, push_m;

  task automatic model_reset();
    q.delete();
    holder = 0;
    sticky = 1'b0;
    last_d = 1'b0;
  endtask

  task automatic model_eval();
    bit          dwin, h_src, h_disc;
    logic [31:0] e_addr;
    g_m = holder;
    if (holder == 0 && q.size() < DEPTH) begin
`ifdef ARB_ROUND_ROBIN_EN
      dwin = bus.data_req && (!bus.inst_req || !last_d);
`else
      dwin = bus.data_req;
`endif
      if (dwin)              g_m = 2;
      else if (bus.inst_req) g_m = 1;
      else                   g_m = 0;
    end
    pop_m  = bus.data_ok && q.size() > 0;
    push_m = g_m != 0 && bus.addr_ok;
    h_src  = 1'b0;
    h_disc = 1'b0;
    if (q.size() > 0) begin
      h_src  = q[0].src;
      h_disc = q[0].disc;
    end
    e_addr = (g_m == 2) ? bus.data_addr : (g_m == 1) ? bus.inst_addr : 32'd0;
    check("req",          32'(bus.req),   32'(g_m != 0));
    check("addr",         bus.addr,       e_addr);
    check("wr",           32'(bus.wr),    32'(g_m == 2 && bus.data_wr));
    check("size",         32'(bus.size),  (g_m == 2) ? 32'(bus.data_size) : (g_m == 1) ? 32'd2 : 32'd0);
    check("wstrb",        32'(bus.wstrb), (g_m == 2) ? 32'(bus.data_wstrb) : 32'd0);
    check("wdata",        bus.wdata,      (g_m == 2) ? bus.data_wdata : 32'd0);
    check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(bus.addr_ok && g_m == 1));
    check("data_addr_ok", 32'(bus.data_addr_ok), 32'(bus.addr_ok && g_m == 2));
    check("inst_data_ok", 32'(bus.inst_data_ok), 32'(pop_m && !h_src && !h_disc && !bus.inst_cancel));
    check("data_data_ok", 32'(bus.data_data_ok), 32'(pop_m && h_src));
    check("inst_rdata",   bus.inst_rdata, bus.rdata);
    check("data_rdata",   bus.data_rdata, bus.rdata);
  endtask

  task automatic model_commit();
    ent_t e;
    if (pop_m) void'(q.pop_front());
    if (bus.inst_cancel)
      foreach (q[i]) if (!q[i].src) q[i].disc = 1'b1;
    if (push_m) begin
      e.src  = (g_m == 2);
      e.disc = (g_m == 1) && (bus.inst_cancel || sticky);
      q.push_back(e);
    end
    if (push_m && g_m == 1)               sticky = 1'b0;
    else if (holder == 1 && bus.inst_cancel) sticky = 1'b1;
    if (holder == 0 && g_m != 0) last_d = (g_m == 2);
    holder = push_m ? 0 : g_m;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // One cycle with explicit hand-derived expectations on top of the model.
  task automatic cycle_chk(input string nm, input bit e_req, input bit e_iaok, input bit e_idok);
    @(negedge clk);
    check({nm, ".req"},  32'(bus.req),          32'(e_req));
    check({nm, ".iaok"}, 32'(bus.inst_addr_ok), 32'(e_iaok));
    check({nm, ".idok"}, 32'(bus.inst_data_ok), 32'(e_idok));
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.inst_cancel = 1'b0;
    bus.addr_ok = 1'b0;  bus.data_ok = 1'b0;  bus.rdata = 32'd0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ir, dr, aok, dok;
    logic [31:0] rd;
    bit e_req, e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  vec_t tbl[19];

  initial begin
    //          ir dr aok dok rdata          req iaok daok idok ddok
    tbl[0]  = '{0, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 32'hDEADBEEF,  0, 0, 0, 0, 1};
    tbl[4]  = '{1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 32'h11111111,  0, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 32'h22222222,  0, 0, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 1, 32'h33333333,  1, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 32'h44444444,  0, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 32'h55555555,  0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0};
`ifdef ARB_ROUND_ROBIN_EN
    tbl[14] = '{1, 1, 1, 0, 32'h0,         1, 1, 0, 0, 0};
`else
    tbl[14] = '{1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0};
`endif
    tbl[15] = '{1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 32'h66666666,  0, 0, 0, 0, 1};
`ifdef ARB_ROUND_ROBIN_EN
    tbl[17] = '{0, 0, 0, 1, 32'h77777777,  0, 0, 0, 1, 0};
`else
    tbl[17] = '{0, 0, 0, 1, 32'h77777777,  0, 0, 0, 0, 1};
`endif
    tbl[18] = '{0, 0, 0, 1, 32'h88888888,  0, 0, 0, 1, 0};
  end

  // ---------------- main test ----------------
  initial begin
    idle_inputs();
    bus.inst_addr = 32'hBFC0_0000;
    bus.data_addr = 32'h1000_0004;
    bus.data_wr = 1'b0; bus.data_size = 2'd2; bus.data_wstrb = 4'hF; bus.data_wdata = 32'h0;
    model_reset();

    // Reset state: requests present, outputs must stay low.
    bus.data_req = 1'b1; bus.addr_ok = 1'b1; bus.data_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req",  32'(bus.req),          32'd0);
    check("rst.daok", 32'(bus.data_addr_ok), 32'd0);
    check("rst.ddok", 32'(bus.data_data_ok), 32'd0);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors: single load, ordering, ignored data_ok, contention.
    for (int i = 0; i < 19; i++) begin
      bus.inst_req = tbl[i].ir;
      bus.data_req = tbl[i].dr;
      bus.addr_ok  = tbl[i].aok;
      bus.data_ok  = tbl[i].dok;
      bus.rdata    = tbl[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d.req", i),  32'(bus.req),          32'(tbl[i].e_req));
      check($sformatf("vec%0d.iaok", i), 32'(bus.inst_addr_ok), 32'(tbl[i].e_iaok));
      check($sformatf("vec%0d.daok", i), 32'(bus.data_addr_ok), 32'(tbl[i].e_daok));
      check($sformatf("vec%0d.idok", i), 32'(bus.inst_data_ok), 32'(tbl[i].e_idok));
      check($sformatf("vec%0d.ddok", i), 32'(bus.data_data_ok), 32'(tbl[i].e_ddok));
      if (tbl[i].e_ddok)
        check($sformatf("vec%0d.rdata", i), bus.data_rdata, tbl[i].rd);
      model_eval();
      model_commit();
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // Full: four fetches fill the tracker, the fifth waits for one response.
    bus.inst_req = 1'b1; bus.addr_ok = 1'b1;
    repeat (4) cycle_chk("full_fill", 1, 1, 0);
    bus.addr_ok = 1'b0;
    repeat (2) cycle_chk("full_block", 0, 0, 0);
    bus.data_ok = 1'b1;
    cycle_chk("full_pop", 0, 0, 1);
    bus.data_ok = 1'b0; bus.addr_ok = 1'b1;
    cycle_chk("full_5th", 1, 1, 0);
    bus.addr_ok = 1'b0;
    cycle_chk("full_again", 0, 0, 0);
    bus.inst_req = 1'b0; bus.data_ok = 1'b1;
    repeat (4) cycle_chk("full_drain", 0, 0, 1);
    idle_inputs();

    // Cancel: two fetches in flight, a third held, then a flush pulse.
    bus.inst_req = 1'b1; bus.addr_ok = 1'b1;
    repeat (2) cycle_chk("cxl_issue", 1, 1, 0);
    bus.addr_ok = 1'b0;
    cycle_chk("cxl_present", 1, 0, 0);
    bus.inst_req = 1'b0; bus.inst_cancel = 1'b1;
    cycle_chk("cxl_hold", 1, 0, 0);
    bus.inst_cancel = 1'b0; bus.addr_ok = 1'b1;
    cycle_chk("cxl_accept", 1, 1, 0);
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1;
    repeat (3) cycle_chk("cxl_drop", 0, 0, 0);
    bus.data_ok = 1'b0; bus.inst_req = 1'b1; bus.addr_ok = 1'b1;
    cycle_chk("cxl_new", 1, 1, 0);
    bus.inst_req = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hCAFE_F00D;
    cycle_chk("cxl_return", 0, 0, 1);
    idle_inputs();

    // Reset mid-HOLD_D with two transactions outstanding.
    bus.data_req = 1'b1; bus.addr_ok = 1'b1;
    repeat (2) cycle();
    bus.addr_ok = 1'b0;
    cycle();
    reset = 1'b0;
    bus.addr_ok = 1'b1; bus.data_ok = 1'b1;
    #1;
    check("midrst.req",  32'(bus.req),          32'd0);
    check("midrst.daok", 32'(bus.data_addr_ok), 32'd0);
    check("midrst.ddok", 32'(bus.data_data_ok), 32'd0);
    check("midrst.idok", 32'(bus.inst_data_ok), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    check("post_rst.state", 32'(dut.state), 32'd0);
    check("post_rst.count", 32'(dut.count), 32'd0);
    cycle_chk("post_rst", 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      bus.inst_req    = ($urandom_range(99) < 60);
      bus.data_req    = ($urandom_range(99) < 40);
      bus.addr_ok     = ($urandom_range(99) < 50);
      bus.data_ok     = ($urandom_range(99) < 40);
      bus.inst_cancel = ($urandom_range(99) < 5);
      bus.inst_addr   = $urandom;
      bus.data_addr   = $urandom;
      bus.data_wr     = 1'($urandom_range(1));
      bus.data_size   = 2'($urandom_range(2));
      bus.data_wstrb  = 4'($urandom_range(15));
      bus.data_wdata  = $urandom;
      bus.rdata       = $urandom;
      cycle();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
